// File: rtl/tiny16_pkg.sv
// Shared arbiter types: FSM state encoding, owner tags, counter sizing helper.
package tiny16_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_CPU  = 2'd1,
        ARB_DMA  = 2'd2
    } arb_state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    function automatic int burst_cnt_w(input int max_burst);
        return (max_burst > 1) ? $clog2(max_burst) : 1;
    endfunction

endpackage

// File: rtl/arb_burst_cnt.sv
// Purpose: counts DMA accesses in the current burst, flags the last permitted one.
// Latency: term reflects the registered count (no input-to-term path).
// Backpressure: none; saturates at MAX_BURST-1 until cleared.
module arb_burst_cnt
    import tiny16_pkg::*;
#(
    parameter int MAX_BURST = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic term
);

    localparam int CW = burst_cnt_w(MAX_BURST);
    localparam logic [CW-1:0] TERM_VAL = CW'(MAX_BURST - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && !term) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign term = (cnt == TERM_VAL);

endmodule

// File: rtl/mem_arbiter.sv
// Purpose: CPU/DMA arbiter for the single memory port; ARB_ROUND_ROBIN_EN selects RR tie-break in IDLE.
// Latency: grant one cycle after request in IDLE; rvalid one cycle after a read strobe.
// Backpressure: un-granted requests are ignored; DMA bursts capped at MAX_BURST while CPU waits.
module mem_arbiter
    import tiny16_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rdata
);

    arb_state_t state;
    arb_state_t state_nxt;
    logic       cpu_acc;
    logic       dma_acc;
    logic       burst_term;
    logic       cpu_first;

    assign cpu_acc = cpu_gnt & cpu_req;
    assign dma_acc = dma_gnt & dma_req;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_owner;

    // Owner is only ever sampled in IDLE, so tracking the owning state is
    // equivalent to updating on each grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner <= OWN_DMA;
        end else if (state == ARB_CPU) begin
            last_owner <= OWN_CPU;
        end else if (state == ARB_DMA) begin
            last_owner <= OWN_DMA;
        end
    end

    assign cpu_first = (last_owner == OWN_DMA);
`else
    assign cpu_first = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: begin
                if (cpu_req && (!dma_req || cpu_first)) begin
                    state_nxt = ARB_CPU;
                end else if (dma_req) begin
                    state_nxt = ARB_DMA;
                end
            end
            ARB_CPU: begin
                if (!cpu_req) begin
                    state_nxt = dma_req ? ARB_DMA : ARB_IDLE;
                end
            end
            ARB_DMA: begin
                if (!dma_req) begin
                    state_nxt = cpu_req ? ARB_CPU : ARB_IDLE;
                end else if (cpu_req && burst_term) begin
                    state_nxt = ARB_CPU;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            cpu_gnt    <= 1'b0;
            dma_gnt    <= 1'b0;
            cpu_rvalid <= 1'b0;
            dma_rvalid <= 1'b0;
        end else begin
            state      <= state_nxt;
            cpu_gnt    <= (state_nxt == ARB_CPU);
            dma_gnt    <= (state_nxt == ARB_DMA);
            cpu_rvalid <= cpu_acc & ~cpu_we;
            dma_rvalid <= dma_acc & ~dma_we;
        end
    end

    arb_burst_cnt #(
        .MAX_BURST (MAX_BURST)
    ) u_burst_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_nxt != ARB_DMA),
        .inc  (dma_acc),
        .term (burst_term)
    );

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_en    = cpu_req;
            mem_we    = cpu_req & cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dma_gnt) begin
            mem_en    = dma_req;
            mem_we    = dma_req & dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

    assign rdata = mem_rdata;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single 16-bit memory port between the CPU controller and a DMA requester (display refresh / block copy). Sits between the controller's memory strobes and the RAM. Grants ownership by a three-state FSM and caps DMA bursts so the CPU is never starved. Read data returns one cycle after the read and is steered back to the requester that issued it.

## Interface
- DATA_W, 16, memory data width
- ADDR_W, 16, memory address width
- MAX_BURST, 8, max consecutive DMA accesses while cpu_req is pending (≥1)

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- cpu_req  in  1  CPU wants the port this cycle
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU owns the port (registered)
- cpu_rvalid  out  1  mem_rdata belongs to CPU read issued last cycle
- dma_req, dma_we, dma_addr, dma_wdata  in  1/1/ADDR_W/DATA_W  DMA equivalents
- dma_gnt  out  1  DMA owns the port (registered)
- dma_rvalid  out  1  mem_rdata belongs to DMA read issued last cycle
- mem_en  out  1  access strobe to RAM
- mem_we  out  1  write strobe to RAM
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after read strobe
- rdata  out  DATA_W  mem_rdata passed through to both requesters

## Operation
- States: IDLE, CPU, DMA. cpu_gnt = (state==CPU), dma_gnt = (state==DMA).
- IDLE: cpu_req only -> CPU; dma_req only -> DMA; both -> CPU (fixed priority); none -> IDLE.
- CPU: access issued every cycle cpu_req=1. cpu_req=0 -> DMA if dma_req else IDLE. CPU is never preempted.
- DMA: access issued every cycle dma_req=1; burst counter increments per access, clears on leaving DMA. dma_req=0 -> CPU if cpu_req else IDLE. Counter == MAX_BURST-1 on an access with cpu_req=1 -> CPU next cycle regardless of dma_req.
- Port mux: mem_en = owner_req & owner_gnt; mem_we/addr/wdata = owner's signals; in IDLE mem_en=mem_we=0, addr/wdata=0.
- Read tag: registered; cpu_rvalid (dma_rvalid) = 1 the cycle after a CPU (DMA) access with we=0. Writes never raise rvalid.
- Requester must hold req until its gnt is seen; requests without gnt are ignored, not queued.

## Timing
- Reset: state=IDLE, cpu_gnt=dma_gnt=0, cpu_rvalid=dma_rvalid=0, burst count=0, mem_en=mem_we=0, mem_addr=mem_wdata=0, last-owner=DMA.
- Grant latency: req seen in IDLE -> gnt next cycle -> first access same cycle as gnt.
- Handover CPU<->DMA without IDLE gap; owner's last access and new gnt in adjacent cycles.
- Read latency: rvalid exactly 1 cycle after strobe; back-to-back reads give rvalid every cycle.
- Reset mid-read: rvalid forced 0 in the cycle after rst; in-flight read is dropped.
- Simultaneous drop of owner req and rise of other req: handover that edge.

## Configuration
- ARB_ROUND_ROBIN_EN defined: IDLE with both requests grants the requester that was not last owner (last-owner register updated on every grant); CPU still never preempted, DMA burst cap unchanged.
- Undefined: fixed CPU priority in IDLE; last-owner register not built.

## Structure
- Shared package tiny16_pkg: state encoding (ARB_IDLE, ARB_CPU, ARB_DMA), owner tag constants (OWN_CPU, OWN_DMA).
- Sub-module arb_burst_cnt: clearable counter with terminal flag at MAX_BURST-1; mem_arbiter instantiates one.

## Test plan
- Reset, then cpu_req=1 write 0x0010<-0xBEEF -> cpu_gnt at cycle 1, mem_en=1,mem_we=1,mem_addr=0x0010,mem_wdata=0xBEEF same cycle; dma_gnt stays 0.
- cpu_req and dma_req rise together from IDLE -> cpu_gnt first (RR undefined); with ARB_ROUND_ROBIN_EN after a prior CPU grant -> dma_gnt first.
- DMA streams reads 0x0100..; cpu_req rises on DMA access 3 -> after access 8 (MAX_BURST=8) cpu_gnt next cycle, dma_gnt=0 while dma_req held.
- CPU read of 0x0020 (RAM=0x1234) -> cpu_rvalid=1, rdata=0x1234 one cycle later; dma_rvalid=0.
- CPU drops req while dma_req=1 -> dma_gnt next cycle, no IDLE cycle.
- rst asserted cycle after DMA read strobe -> dma_rvalid=0, all gnts 0, mem_en=0 next cycle.
